// File: rtl/fp_arb_pkg.sv
// Shared definitions for the FP unit sharing arbiter: data width, FP modes,
// arbiter state encoding and fixed requester slot assignments.
package fp_arb_pkg;

    localparam int FP_DATA_W = 48;

    localparam logic FP_MODE_ADD = 1'b0;
    localparam logic FP_MODE_MUL = 1'b1;

    // Fixed requester slots; further requesters (Jacobi iteration) take the next indices
    localparam int REQ_UPDY = 0;
    localparam int REQ_WRY  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

endpackage

// File: rtl/fp_share_arbiter_rr_grant.sv
// Combinational round-robin picker: first valid requester at or after the
// pointer (wrapping), returned as a one-hot grant plus its binary index.
module rr_grant #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [IDX_W-1:0] ptr,
    input  logic [N-1:0]     valid,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    always_comb begin
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && valid[IDX_W'(idx)]) begin
                found                 = 1'b1;
                grant[IDX_W'(idx)]    = 1'b1;
                grant_idx             = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fp_share_arbiter.sv
// Shares one pipelined FP unit between NUM_REQ requesters with round-robin issue
// and a tag pipe that routes each result back. FP_SHARE_ARB_STATS_EN adds counters.
module fp_share_arbiter
    import fp_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int FP_LATENCY = 3,
    parameter int DATA_W     = FP_DATA_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_arbEnable,
    input  logic [NUM_REQ-1:0]        in_reqValid,
    input  logic [NUM_REQ*DATA_W-1:0] in_reqOpA,
    input  logic [NUM_REQ*DATA_W-1:0] in_reqOpB,
    input  logic [NUM_REQ-1:0]        in_reqMode,
    output logic [NUM_REQ-1:0]        op_reqReady,
    output logic [DATA_W-1:0]         op_fpIn1,
    output logic [DATA_W-1:0]         op_fpIn2,
    output logic                      op_fpMode,
    input  logic [DATA_W-1:0]         in_fpOut,
    output logic [NUM_REQ-1:0]        op_rspValid,
    output logic [DATA_W-1:0]         op_rspData,
    output logic                      op_idle
`ifdef FP_SHARE_ARB_STATS_EN
    ,
    output logic [31:0]               op_issueCount,
    output logic [31:0]               op_stallCount
`endif
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STAGES = FP_LATENCY + 1;

    arb_state_e         state_reg;
    arb_state_e         state_next;
    logic [IDX_W-1:0]   ptr_reg;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               issue;
    logic [STAGES-1:0]  tag_vld_reg;
    logic [IDX_W-1:0]   tag_idx_reg [STAGES];
    logic [DATA_W-1:0]  op_a [NUM_REQ];
    logic [DATA_W-1:0]  op_b [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_a[gi] = in_reqOpA[gi*DATA_W +: DATA_W];
            assign op_b[gi] = in_reqOpB[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_grant #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_grant (
        .ptr       (ptr_reg),
        .valid     (in_reqValid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        state_next = state_reg;
        if (reset) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (in_arbEnable) state_next = RUN;
                RUN:     if (!in_arbEnable) state_next = DRAIN;
                DRAIN: begin
                    if (in_arbEnable)            state_next = RUN;
                    else if (tag_vld_reg == '0)  state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Gating on the next state lets a dropping enable block issue in the same cycle
    assign op_reqReady = (state_next == RUN) ? grant : '0;
    assign issue       = |(in_reqValid & op_reqReady);
    assign op_idle     = (state_reg == IDLE) && (tag_vld_reg == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            tag_vld_reg <= '0;
            for (int k = 0; k < STAGES; k++) tag_idx_reg[k] <= '0;
            op_fpIn1    <= '0;
            op_fpIn2    <= '0;
            op_fpMode   <= FP_MODE_ADD;
            op_rspValid <= '0;
            op_rspData  <= '0;
        end else begin
            state_reg      <= state_next;
            tag_vld_reg    <= {tag_vld_reg[STAGES-2:0], issue};
            tag_idx_reg[0] <= grant_idx;
            for (int k = 1; k < STAGES; k++) tag_idx_reg[k] <= tag_idx_reg[k-1];

            if (issue) begin
                ptr_reg   <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
                op_fpIn1  <= op_a[grant_idx];
                op_fpIn2  <= op_b[grant_idx];
                op_fpMode <= in_reqMode[grant_idx];
            end else begin
                op_fpIn1  <= '0;
                op_fpIn2  <= '0;
                op_fpMode <= FP_MODE_ADD;
            end

            // Last tag stage lines up with the cycle in_fpOut carries that op's result
            op_rspValid <= '0;
            if (tag_vld_reg[STAGES-1]) begin
                op_rspValid[tag_idx_reg[STAGES-1]] <= 1'b1;
                op_rspData <= in_fpOut;
            end else begin
                op_rspData <= '0;
            end
        end
    end

`ifdef FP_SHARE_ARB_STATS_EN
    logic [31:0] issue_cnt_reg;
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            issue_cnt_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (issue && issue_cnt_reg != '1)
                issue_cnt_reg <= issue_cnt_reg + 32'd1;
            if ((|in_reqValid) && !issue && stall_cnt_reg != '1)
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign op_issueCount = issue_cnt_reg;
    assign op_stallCount = stall_cnt_reg;
`endif

endmodule
